// File: rtl/beta_operand_unit.sv
// beta_operand_unit
//   Register file and operand sequencer for the Beta ALU. Accepts one
//   OP/OPC instruction per handshake, reads Ra and Rb (or the sign-extended
//   literal), presents them to the external combinational ALU, captures the
//   Rc result and writes it back. One instruction in flight at a time.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   instr_valid/ready   instruction handshake (ready only in IDLE)
//   instr[31:0]         opcode[31:26] rc[25:21] ra[20:16] rb[15:11] lit[15:0]
//   alu_op/ra/rb        ALU inputs, loaded on entry to EXEC and held after
//   alu_rc              combinational ALU result
//   done/result/illegal one-cycle retire pulse with its value and qualifier
//   dbg_addr/dbg_data   combinational debug read port (index 31 reads 0)
module beta_operand_unit #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [5:0]        alu_op,
    output logic [DWIDTH-1:0] alu_ra,
    output logic [DWIDTH-1:0] alu_rb,
    input  logic [DWIDTH-1:0] alu_rc,
    output logic              done,
    output logic [DWIDTH-1:0] result,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DWIDTH-1:0] dbg_data
);

    // Highest index is the hardwired zero register and has no storage.
    localparam int unsigned LAST = NREGS - 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       ir_q;
    logic [5:0]        op_q;
    logic [DWIDTH-1:0] opa_q;
    logic [DWIDTH-1:0] opb_q;
    logic [DWIDTH-1:0] res_q;
    logic              ill_q;
    logic [DWIDTH-1:0] rf_q [LAST];

    logic [5:0]        ir_opcode;
    logic [4:0]        ir_rc;
    logic [4:0]        ir_ra;
    logic [4:0]        ir_rb;
    logic              ir_legal;
    logic [DWIDTH-1:0] ra_val;
    logic [DWIDTH-1:0] rb_val;
    logic [DWIDTH-1:0] lit_ext;

    assign ir_opcode = ir_q[31:26];
    assign ir_rc     = ir_q[25:21];
    assign ir_ra     = ir_q[20:16];
    assign ir_rb     = ir_q[15:11];
    // OP is 2'b10 and OPC is 2'b11 in opcode[5:4]; both have opcode[5] set.
    assign ir_legal  = ir_opcode[5];
    assign lit_ext   = DWIDTH'($signed(ir_q[15:0]));

    // Register-file read ports; the zero register reads as 0.
    always_comb begin
        ra_val   = '0;
        rb_val   = '0;
        dbg_data = '0;
        if (32'(ir_ra) < LAST) begin
            ra_val = rf_q[ir_ra];
        end
        if (32'(ir_rb) < LAST) begin
            rb_val = rf_q[ir_rb];
        end
        if (32'(dbg_addr) < LAST) begin
            dbg_data = rf_q[dbg_addr];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (instr_valid) state_d = READ;
            READ: state_d = ir_legal ? EXEC : WB;
            EXEC: state_d = WB;
            WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            ill_q   <= 1'b0;
            for (int unsigned i = 0; i < LAST; i++) begin
                rf_q[i[4:0]] <= '0;
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (instr_valid) ir_q <= instr;
                end
                READ: begin
                    // Operand registers double as the ALU inputs, so they are
                    // only loaded for legal opcodes to keep alu_* holding.
                    if (ir_legal) begin
                        op_q  <= ir_opcode;
                        opa_q <= ra_val;
                        opb_q <= ir_opcode[4] ? lit_ext : rb_val;
                    end else begin
                        ill_q <= 1'b1;
                        res_q <= '0;
                    end
                end
                EXEC: begin
                    res_q <= alu_rc;
                end
                WB: begin
                    if (!ill_q && (32'(ir_rc) < LAST)) begin
                        rf_q[ir_rc] <= res_q;
                    end
                    ill_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign done        = (state_q == WB);
    assign result      = res_q;
    assign illegal     = ill_q && (state_q == WB);
    assign alu_op      = op_q;
    assign alu_ra      = opa_q;
    assign alu_rb      = opb_q;

endmodule

// File: tb/tb_beta_operand_unit.sv
module tb_beta_operand_unit;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [31:0]   instr = '0;
    logic [5:0]    alu_op;
    logic [DW-1:0] alu_ra;
    logic [DW-1:0] alu_rb;
    logic [DW-1:0] alu_rc;
    logic          done;
    logic [DW-1:0] result;
    logic          illegal;
    logic [4:0]    dbg_addr = '0;
    logic [DW-1:0] dbg_data;

    beta_operand_unit #(
        .DWIDTH(DW),
        .NREGS (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_op     (alu_op),
        .alu_ra     (alu_ra),
        .alu_rb     (alu_rb),
        .alu_rc     (alu_rc),
        .done       (done),
        .result     (result),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;
    int pcnt  = 0;

    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU: low opcode nibble selects the function.
    function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op[3:0])
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h8:    return a & b;
            4'h9:    return a | b;
            4'hA:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    always_comb alu_rc = alu_f(alu_op, alu_ra, alu_rb);

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          due;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [32];

    function automatic logic [31:0] mk(input logic [5:0] op, input int rc, input int ra,
                                       input logic [15:0] lo);
        return {op, 5'(rc), 5'(ra), lo};
    endfunction

    // Offer w until accepted; acc is the pcnt value right after the accept edge.
    task automatic send(input logic [31:0] w, input bit push, output int acc);
        int          n;
        exp_t        e;
        logic [5:0]  op;
        instr       = w;
        instr_valid = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check_eq("accept_timeout", 32'(n), 32'd0);
            instr_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = pcnt + 1;
        if (push) begin
            op    = w[31:26];
            e.op  = op;
            e.ill = ~op[5];
            e.due = acc + (e.ill ? 1 : 2);
            e.a   = mdl[w[20:16]];
            e.b   = op[4] ? {{16{w[15]}}, w[15:0]} : mdl[w[15:11]];
            if (e.ill) begin
                e.res = '0;
            end else begin
                e.res = alu_f(op, e.a, e.b);
                if (w[25:21] != 5'd31) mdl[w[25:21]] = e.res;
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check_eq("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic dbg_check(input string tag, input int idx);
        dbg_addr = 5'(idx);
        #1;
        check_eq(tag, dbg_data, mdl[idx]);
    endtask

    // Scoreboard consumer: retire checks on done, ALU input checks in EXEC.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            check_eq("done_gap", 32'(prev_done), 32'd0);
            if (sbq.size() == 0) begin
                check_eq("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sbq.pop_front();
                check_eq("result", result, e.res);
                check_eq("illegal", 32'(illegal), 32'(e.ill));
                check_eq("done_latency", 32'(pcnt), 32'(e.due));
            end
        end else if (sbq.size() != 0 && !sbq[0].ill && pcnt == sbq[0].due - 1) begin
            check_eq("alu_op", 32'(alu_op), 32'(sbq[0].op));
            check_eq("alu_ra", alu_ra, sbq[0].a);
            check_eq("alu_rb", alu_rb, sbq[0].b);
        end
        prev_done = (done === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int a1, a2;
        logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h28, 6'h29, 6'h2A,
                                 6'h30, 6'h31, 6'h38, 6'h39, 6'h3A};
        for (int i = 0; i < 32; i++) mdl[i] = '0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(instr_ready), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_alu_op", 32'(alu_op), 32'd0);
        check_eq("rst_alu_ra", alu_ra, 32'd0);
        check_eq("rst_alu_rb", alu_rb, 32'd0);
        rst = 1'b0;
        dbg_check("rst_r0", 0);
        @(negedge clk);
        check_eq("ready_after_rst", 32'(instr_ready), 32'd1);

        // Load R1=5, R2=7, then R3=R1+R2.
        send(mk(6'h30, 1, 31, 16'd5), 1, a1);
        instr_valid = 1'b0; drain();
        send(mk(6'h30, 2, 31, 16'd7), 1, a1);
        instr_valid = 1'b0; drain();
        send({6'h20, 5'd3, 5'd1, 5'd2, 11'd0}, 1, a1);
        instr_valid = 1'b0; drain();
        dbg_check("dbg_r3", 3);
        check_eq("r3_is_12", mdl[3], 32'd12);

        // Negative literal and sign extension.
        send(mk(6'h31, 4, 31, 16'h0001), 1, a1);
        instr_valid = 1'b0; drain();
        dbg_check("dbg_r4", 4);
        send(mk(6'h30, 6, 31, 16'h8000), 1, a1);
        instr_valid = 1'b0; drain();
        dbg_check("dbg_r6", 6);

        // Write to the zero register is discarded.
        send(mk(6'h30, 31, 31, 16'd9), 1, a1);
        instr_valid = 1'b0; drain();
        dbg_check("dbg_r31", 31);

        // Illegal opcode: no register changes anywhere.
        send(mk(6'h01, 7, 1, 16'h1234), 1, a1);
        instr_valid = 1'b0; drain();
        for (int i = 0; i < 32; i++) dbg_check("sweep_after_illegal", i);

        // Back-to-back with a dependency on the previous destination.
        send(mk(6'h30, 7, 1, 16'h0010), 1, a1);
        send({6'h20, 5'd8, 5'd7, 5'd2, 11'd0}, 1, a2);
        instr_valid = 1'b0;
        check_eq("b2b_gap", 32'(a2 - a1), 32'd4);
        drain();
        dbg_check("dbg_r8", 8);

        // Random legal traffic over all ALU functions.
        for (int k = 0; k < 8; k++) begin
            send({ops[$urandom_range(0, 9)], 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 16'($urandom)}, 1, a1);
            instr_valid = 1'b0;
            drain();
        end
        for (int i = 0; i < 32; i++) dbg_check("sweep_random", i);

        // Reset during EXEC abandons the instruction.
        send(mk(6'h30, 5, 31, 16'd3), 0, a1);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        @(negedge clk);
        check_eq("ready_after_mid_rst", 32'(instr_ready), 32'd1);
        repeat (5) @(negedge clk);
        dbg_check("r5_after_mid_rst", 5);
        dbg_check("r1_after_mid_rst", 1);
        send(mk(6'h30, 9, 31, 16'h0011), 1, a1);
        instr_valid = 1'b0; drain();
        dbg_check("dbg_r9", 9);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
